// File: rtl/rs_issue_scheduler.sv
// Age-matrix issue scheduler: picks up to WAYS oldest ready RS entries per cycle and binds them to free ALU lanes.
// clear_mask/num_issued are combinational; lane grants are registered and reach EX one cycle later.
module rs_issue_scheduler #(
  parameter int RS   = 16,
  parameter int WAYS = 3,
  parameter int IDXW = $clog2(RS)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic [RS-1:0]          alloc_mask_i,
  input  logic [RS-1:0]          entry_ready_i,
  input  logic [WAYS-1:0]        alu_busy_i,
  output logic [RS-1:0]          clear_mask_o,
  output logic [$clog2(WAYS):0]  num_issued_o,
  output logic [WAYS-1:0]        issue_valid_o,
  output logic [WAYS*IDXW-1:0]   issue_idx_o,
  output logic [$clog2(RS):0]    occupancy_o
);

  localparam int NIW  = $clog2(WAYS) + 1;
  localparam int OCCW = $clog2(RS) + 1;

  logic [RS-1:0]                valid_q, valid_d;
  logic [RS-1:0][RS-1:0]        older_q, older_d;
  logic [WAYS-1:0]              issue_valid_q, issue_valid_d;
  logic [WAYS-1:0][IDXW-1:0]    issue_idx_q, issue_idx_d;
  logic [OCCW-1:0]              occ_q, occ_d;

  logic [RS-1:0] grant;
  logic [RS-1:0] rem;
  logic [RS-1:0] pick;

  // older[j][i]=1 means j was allocated before i; an entry is oldest if no remaining entry is older.
  function automatic logic [RS-1:0] pick_oldest(input logic [RS-1:0] cand,
                                                input logic [RS-1:0][RS-1:0] older);
    logic [RS-1:0] oh;
    logic          found;
    logic          hit;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < RS; i++) begin
      hit = cand[i];
      for (int j = 0; j < RS; j++) begin
        if (cand[j] && older[j][i]) hit = 1'b0;
      end
      if (hit && !found) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [IDXW-1:0] onehot_idx(input logic [RS-1:0] oh);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < RS; i++) begin
      if (oh[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    rem           = (reset_i || flush_i) ? '0 : (valid_q & entry_ready_i);
    grant         = '0;
    pick          = '0;
    issue_valid_d = '0;
    issue_idx_d   = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (!alu_busy_i[k]) begin
        pick = pick_oldest(rem, older_q);
        if (|pick) begin
          grant          = grant | pick;
          issue_valid_d[k] = 1'b1;
          issue_idx_d[k]   = onehot_idx(pick);
          rem            = rem & ~pick;
        end
      end
    end
  end

  // New entries are younger than every surviving entry; among same-cycle allocs lower index is older.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < RS; i++) begin
      for (int j = 0; j < RS; j++) begin
        if (alloc_mask_i[i]) begin
          older_d[i][j] = alloc_mask_i[j] && (j > i);
        end else if (alloc_mask_i[j]) begin
          older_d[i][j] = valid_q[i];
        end
      end
    end
  end

  always_comb begin
    valid_d = (valid_q & ~grant) | alloc_mask_i;
    occ_d   = occ_q + OCCW'($countones(alloc_mask_i)) - OCCW'($countones(grant));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      valid_q       <= '0;
      older_q       <= '0;
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
      occ_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      older_q       <= older_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      occ_q         <= occ_d;
    end
  end

  assign clear_mask_o  = grant;
  assign num_issued_o  = NIW'($countones(grant));
  assign issue_valid_o = issue_valid_q;
  assign issue_idx_o   = issue_idx_q;
  assign occupancy_o   = occ_q;

  a_alloc_free: assert property (@(posedge clock_i) disable iff (reset_i || flush_i)
                                 (alloc_mask_i & valid_q) == '0);

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: age ordering, lane binding, busy lanes, flush, full station.
module tb_rs_issue_scheduler;
  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic [15:0] alloc_mask_i;
  logic [15:0] entry_ready_i;
  logic [2:0]  alu_busy_i;
  logic [15:0] clear_mask_o;
  logic [2:0]  num_issued_o;
  logic [2:0]  issue_valid_o;
  logic [11:0] issue_idx_o;
  logic [4:0]  occupancy_o;

  int checks = 0;
  int errors = 0;

  rs_issue_scheduler dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .alloc_mask_i (alloc_mask_i),
    .entry_ready_i(entry_ready_i),
    .alu_busy_i   (alu_busy_i),
    .clear_mask_o (clear_mask_o),
    .num_issued_o (num_issued_o),
    .issue_valid_o(issue_valid_o),
    .issue_idx_o  (issue_idx_o),
    .occupancy_o  (occupancy_o)
  );

  always #5 clock_i = ~clock_i;

  // Advance one edge and settle 1ns past it.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; flush_i = 1'b0; alloc_mask_i = 16'hFFFF;
    entry_ready_i = 16'hFFFF; alu_busy_i = 3'b000;
    tick();
    #1;
    checks++; if (clear_mask_o !== 16'h0000) begin errors++; $display("FAIL reset_clear got %h exp %h", clear_mask_o, 16'h0000); end
    checks++; if (num_issued_o !== 3'd0) begin errors++; $display("FAIL reset_num got %0d exp 0", num_issued_o); end
    tick();
    checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy_o); end
    checks++; if (issue_valid_o !== 3'b000) begin errors++; $display("FAIL reset_ivalid got %b exp 000", issue_valid_o); end
    checks++; if (issue_idx_o !== 12'h000) begin errors++; $display("FAIL reset_idx got %h exp 000", issue_idx_o); end
    reset_i = 1'b0; alloc_mask_i = 16'h0000;
    #1;
    checks++; if (clear_mask_o !== 16'h0000) begin errors++; $display("FAIL reset_noalloc got %h exp %h", clear_mask_o, 16'h0000); end
    tick();
    entry_ready_i = 16'h0000;
  endtask

  task automatic test_age_order();
    alloc_mask_i = 16'h0020; tick();
    alloc_mask_i = 16'h0004; tick();
    alloc_mask_i = 16'h0200; tick();
    alloc_mask_i = 16'h0000;
    checks++; if (occupancy_o !== 5'd3) begin errors++; $display("FAIL age_occ3 got %0d exp 3", occupancy_o); end
    entry_ready_i = 16'hFFFF;
    #1;
    checks++; if (clear_mask_o !== 16'h0224) begin errors++; $display("FAIL age_clear got %h exp %h", clear_mask_o, 16'h0224); end
    checks++; if (num_issued_o !== 3'd3) begin errors++; $display("FAIL age_num got %0d exp 3", num_issued_o); end
    tick();
    checks++; if (issue_valid_o !== 3'b111) begin errors++; $display("FAIL age_ivalid got %b exp 111", issue_valid_o); end
    checks++; if (issue_idx_o !== 12'h925) begin errors++; $display("FAIL age_idx got %h exp 925", issue_idx_o); end
    checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL age_occ0 got %0d exp 0", occupancy_o); end
    entry_ready_i = 16'h0000;
  endtask

  task automatic test_busy_lanes();
    alloc_mask_i = 16'h0020; tick();
    alloc_mask_i = 16'h0004; tick();
    alloc_mask_i = 16'h0200; tick();
    alloc_mask_i = 16'h0000; alu_busy_i = 3'b101; entry_ready_i = 16'hFFFF;
    #1;
    checks++; if (clear_mask_o !== 16'h0020) begin errors++; $display("FAIL busy_clear1 got %h exp %h", clear_mask_o, 16'h0020); end
    tick();
    checks++; if (issue_valid_o !== 3'b010) begin errors++; $display("FAIL busy_ivalid1 got %b exp 010", issue_valid_o); end
    checks++; if (issue_idx_o !== 12'h050) begin errors++; $display("FAIL busy_idx1 got %h exp 050", issue_idx_o); end
    checks++; if (occupancy_o !== 5'd2) begin errors++; $display("FAIL busy_occ1 got %0d exp 2", occupancy_o); end
    alu_busy_i = 3'b000;
    #1;
    checks++; if (clear_mask_o !== 16'h0204) begin errors++; $display("FAIL busy_clear2 got %h exp %h", clear_mask_o, 16'h0204); end
    tick();
    checks++; if (issue_valid_o !== 3'b011) begin errors++; $display("FAIL busy_ivalid2 got %b exp 011", issue_valid_o); end
    checks++; if (issue_idx_o !== 12'h092) begin errors++; $display("FAIL busy_idx2 got %h exp 092", issue_idx_o); end
    checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL busy_occ2 got %0d exp 0", occupancy_o); end
    entry_ready_i = 16'h0000;
  endtask

  task automatic test_same_cycle_alloc();
    alloc_mask_i = 16'h0003; entry_ready_i = 16'hFFFF; alu_busy_i = 3'b011;
    #1;
    checks++; if (clear_mask_o !== 16'h0000) begin errors++; $display("FAIL same_newnotcand got %h exp %h", clear_mask_o, 16'h0000); end
    tick();
    alloc_mask_i = 16'h0000;
    #1;
    checks++; if (clear_mask_o !== 16'h0001) begin errors++; $display("FAIL same_clear1 got %h exp %h", clear_mask_o, 16'h0001); end
    tick();
    checks++; if (issue_valid_o !== 3'b100) begin errors++; $display("FAIL same_ivalid1 got %b exp 100", issue_valid_o); end
    checks++; if (issue_idx_o !== 12'h000) begin errors++; $display("FAIL same_idx1 got %h exp 000", issue_idx_o); end
    checks++; if (occupancy_o !== 5'd1) begin errors++; $display("FAIL same_occ1 got %0d exp 1", occupancy_o); end
    alu_busy_i = 3'b000;
    #1;
    checks++; if (clear_mask_o !== 16'h0002) begin errors++; $display("FAIL same_clear2 got %h exp %h", clear_mask_o, 16'h0002); end
    tick();
    checks++; if (issue_valid_o !== 3'b001) begin errors++; $display("FAIL same_ivalid2 got %b exp 001", issue_valid_o); end
    checks++; if (issue_idx_o !== 12'h001) begin errors++; $display("FAIL same_idx2 got %h exp 001", issue_idx_o); end
    entry_ready_i = 16'h0000;
  endtask

  task automatic test_oldest_not_ready();
    // Allocation order: 3, 7, {1,12}, {4,10}.
    alloc_mask_i = 16'h0008; tick();
    alloc_mask_i = 16'h0080; tick();
    alloc_mask_i = 16'h1002; tick();
    alloc_mask_i = 16'h0410; tick();
    alloc_mask_i = 16'h0000;
    checks++; if (occupancy_o !== 5'd6) begin errors++; $display("FAIL nr_occ6 got %0d exp 6", occupancy_o); end
    entry_ready_i = 16'hFFF7;
    #1;
    checks++; if (clear_mask_o !== 16'h1082) begin errors++; $display("FAIL nr_clear1 got %h exp %h", clear_mask_o, 16'h1082); end
    tick();
    checks++; if (issue_idx_o !== 12'hC17) begin errors++; $display("FAIL nr_idx1 got %h exp C17", issue_idx_o); end
    checks++; if (occupancy_o !== 5'd3) begin errors++; $display("FAIL nr_occ3 got %0d exp 3", occupancy_o); end
    entry_ready_i = 16'hFFFF;
    #1;
    checks++; if (clear_mask_o !== 16'h0418) begin errors++; $display("FAIL nr_clear2 got %h exp %h", clear_mask_o, 16'h0418); end
    tick();
    checks++; if (issue_idx_o !== 12'hA43) begin errors++; $display("FAIL nr_idx2 got %h exp A43", issue_idx_o); end
    checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL nr_occ0 got %0d exp 0", occupancy_o); end
    entry_ready_i = 16'h0000;
  endtask

  task automatic test_flush();
    alloc_mask_i = 16'h0007; tick();
    alloc_mask_i = 16'h0038; tick();
    alloc_mask_i = 16'h00C0; tick();
    alloc_mask_i = 16'h0000;
    checks++; if (occupancy_o !== 5'd8) begin errors++; $display("FAIL flush_occ8 got %0d exp 8", occupancy_o); end
    checks++; if (issue_valid_o !== 3'b000) begin errors++; $display("FAIL flush_ivalid_idle got %b exp 000", issue_valid_o); end
    entry_ready_i = 16'hFFFF; flush_i = 1'b1;
    #1;
    checks++; if (clear_mask_o !== 16'h0000) begin errors++; $display("FAIL flush_clear got %h exp %h", clear_mask_o, 16'h0000); end
    checks++; if (num_issued_o !== 3'd0) begin errors++; $display("FAIL flush_num got %0d exp 0", num_issued_o); end
    tick();
    flush_i = 1'b0;
    checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL flush_occ0 got %0d exp 0", occupancy_o); end
    checks++; if (issue_valid_o !== 3'b000) begin errors++; $display("FAIL flush_ivalid got %b exp 000", issue_valid_o); end
    #1;
    checks++; if (clear_mask_o !== 16'h0000) begin errors++; $display("FAIL flush_after_clear got %h exp %h", clear_mask_o, 16'h0000); end
    tick();
    entry_ready_i = 16'h0000;
  endtask

  task automatic test_full_all_busy();
    logic [15:0] masks [6];
    masks = '{16'h0007, 16'h0038, 16'h01C0, 16'h0E00, 16'h7000, 16'h8000};
    for (int m = 0; m < 6; m++) begin
      alloc_mask_i = masks[m];
      tick();
    end
    alloc_mask_i = 16'h0000;
    checks++; if (occupancy_o !== 5'd16) begin errors++; $display("FAIL full_occ16 got %0d exp 16", occupancy_o); end
    alu_busy_i = 3'b111; entry_ready_i = 16'hFFFF;
    #1;
    checks++; if (clear_mask_o !== 16'h0000) begin errors++; $display("FAIL full_allbusy_clear got %h exp %h", clear_mask_o, 16'h0000); end
    tick();
    checks++; if (issue_valid_o !== 3'b000) begin errors++; $display("FAIL full_allbusy_ivalid got %b exp 000", issue_valid_o); end
    checks++; if (occupancy_o !== 5'd16) begin errors++; $display("FAIL full_allbusy_occ got %0d exp 16", occupancy_o); end
    alu_busy_i = 3'b000;
    #1;
    checks++; if (clear_mask_o !== 16'h0007) begin errors++; $display("FAIL full_clear got %h exp %h", clear_mask_o, 16'h0007); end
    tick();
    checks++; if (issue_valid_o !== 3'b111) begin errors++; $display("FAIL full_ivalid got %b exp 111", issue_valid_o); end
    checks++; if (issue_idx_o !== 12'h210) begin errors++; $display("FAIL full_idx got %h exp 210", issue_idx_o); end
    checks++; if (occupancy_o !== 5'd13) begin errors++; $display("FAIL full_occ13 got %0d exp 13", occupancy_o); end
    entry_ready_i = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_age_order();
    test_busy_lanes();
    test_same_cycle_alloc();
    test_oldest_not_ready();
    test_flush();
    test_full_all_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
